// File: rtl/decode_stage.sv
// decode_stage: registered miniMips decoder between fetch and execute, with valid/ready
// handshakes, PC carry, flush, and a load-use interlock that inserts bubbles after Ldr.
module decode_stage #(
   parameter int INSTR_W  = 9,
   parameter int PC_W     = 10,
   parameter int IMM_W    = 8,
   parameter int LOAD_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [1:0]         R1,
   output logic [1:0]         R2,
   output logic [1:0]         W,
   output logic               write_en,
   output logic               mem_write,
   output logic               mem_read,
   output logic               use_alu_bypass,
   output logic               alu_src,
   output logic [IMM_W-1:0]   imm,
   output logic [4:0]         alu_op
);
   localparam int HZ_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

   typedef struct packed {
      logic [1:0] r1;
      logic [1:0] r2;
      logic [1:0] w;
      logic       we;
      logic       mw;
      logic       mr;
      logic       ub;
      logic       as;
      logic [3:0] imm;
      logic [4:0] alu;
   } bundle_t;

   logic [8:0]      ins;
   logic [4:0]      jmp_alu;
   bundle_t         dec;
   logic            rd1;
   logic            rd2;
   bundle_t         bundle_d, bundle_q;
   logic [PC_W-1:0] pc_d, pc_q;
   logic            valid_d, valid_q;
   logic [HZ_W-1:0] hz_cnt_d, hz_cnt_q;
   logic [1:0]      hz_reg_d, hz_reg_q;
   logic            advance;
   logic            stall;
   logic            take;
   logic            ld_out;

   assign ins = in_instr[8:0];

   always_comb begin
      case (ins[5:2])
         4'd4:    jmp_alu = 5'd13;
         4'd5:    jmp_alu = 5'd14;
         4'd6:    jmp_alu = 5'd15;
         4'd7:    jmp_alu = 5'd16;
         4'd8:    jmp_alu = 5'd17;
         4'd10:   jmp_alu = 5'd18;
         4'd11:   jmp_alu = 5'd19;
         4'd15:   jmp_alu = 5'd20;
         4'd12:   jmp_alu = 5'd4;
         4'd13:   jmp_alu = 5'd5;
         4'd14:   jmp_alu = 5'd6;
         default: jmp_alu = 5'd19;
      endcase
   end

   // rd1/rd2 mark which decoded register fields are real reads, for the interlock
   always_comb begin
      dec = '0;
      rd1 = 1'b0;
      rd2 = 1'b0;
      case (ins[8:6])
         3'b000: begin
            dec.r1  = ins[3:2];
            dec.r2  = ins[5:4];
            dec.imm = {2'b00, ins[1:0]};
            dec.mw  = 1'b1;
            dec.as  = 1'b1;
            rd1     = 1'b1;
            rd2     = 1'b1;
         end
         3'b001: begin
            dec.r1  = ins[3:2];
            dec.w   = ins[5:4];
            dec.we  = 1'b1;
            dec.imm = {2'b00, ins[1:0]};
            dec.mr  = 1'b1;
            dec.as  = 1'b1;
            rd1     = 1'b1;
         end
         3'b010: begin
            dec.w   = ins[5:4];
            dec.we  = 1'b1;
            dec.imm = ins[3:0];
            dec.alu = 5'd7;
            dec.ub  = 1'b1;
            dec.as  = 1'b1;
         end
         3'b011: begin
            dec.r1  = ins[5:4];
            dec.w   = ins[5:4];
            dec.we  = 1'b1;
            dec.ub  = 1'b1;
            dec.as  = 1'b1;
            dec.alu = ins[3] ? 5'd10 : 5'd11;
            dec.imm = ins[3] ? 4'd0 - ins[3:0] : ins[3:0];
            rd1     = 1'b1;
         end
         3'b100: begin
            dec.r1  = ins[3:2];
            dec.r2  = ins[1:0];
            dec.w   = (ins[5:4] == 2'd3) ? ins[1:0] : ins[3:2];
            dec.we  = 1'b1;
            dec.ub  = 1'b1;
            dec.alu = (ins[5:4] == 2'd0) ? 5'd0 :
                      (ins[5:4] == 2'd1) ? 5'd1 :
                      (ins[5:4] == 2'd2) ? 5'd3 : 5'd2;
            rd1     = 1'b1;
            rd2     = 1'b1;
         end
         3'b101: begin
            dec.ub  = 1'b1;
            dec.r2  = ins[1:0];
            rd2     = 1'b1;
            if (ins[5:4] == 2'd0) begin
               dec.r1  = ins[3:2];
               dec.alu = 5'd12;
               rd1     = 1'b1;
            end else begin
               dec.w   = ins[1:0];
               dec.alu = jmp_alu;
               dec.we  = (ins[5:4] == 2'd3) && (ins[3:2] != 2'd3);
            end
         end
         default: begin
            dec.r1  = ins[3:2];
            dec.r2  = ins[1:0];
            dec.w   = ins[5:4];
            dec.we  = 1'b1;
            dec.ub  = 1'b1;
            dec.alu = ins[6] ? 5'd8 : 5'd9;
            rd1     = 1'b1;
            rd2     = 1'b1;
         end
      endcase
   end

   // flush outranks every other event; a new Ldr leaving reloads the counter over decrement
   always_comb begin
      advance  = !valid_q || out_ready;
      stall    = (hz_cnt_q != '0) && in_valid &&
                 ((rd1 && dec.r1 == hz_reg_q) || (rd2 && dec.r2 == hz_reg_q));
      in_ready = advance && !stall && !flush;
      take     = in_valid && in_ready;
      ld_out   = valid_q && out_ready && bundle_q.mr;
      valid_d  = flush ? 1'b0 : take ? 1'b1 : advance ? 1'b0 : valid_q;
      bundle_d = take ? dec : bundle_q;
      pc_d     = take ? in_pc : pc_q;
      hz_cnt_d = flush ? '0 :
                 ld_out ? HZ_W'(LOAD_LAT) :
                 (hz_cnt_q != '0) ? hz_cnt_q - HZ_W'(1) : hz_cnt_q;
      hz_reg_d = (ld_out && !flush) ? bundle_q.w : hz_reg_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
         pc_q     <= '0;
         hz_cnt_q <= '0;
         hz_reg_q <= '0;
      end else begin
         valid_q  <= valid_d;
         bundle_q <= bundle_d;
         pc_q     <= pc_d;
         hz_cnt_q <= hz_cnt_d;
         hz_reg_q <= hz_reg_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_pc         = pc_q;
   assign R1             = bundle_q.r1;
   assign R2             = bundle_q.r2;
   assign W              = bundle_q.w;
   assign write_en       = bundle_q.we;
   assign mem_write      = bundle_q.mw;
   assign mem_read       = bundle_q.mr;
   assign use_alu_bypass = bundle_q.ub;
   assign alu_src        = bundle_q.as;
   assign imm            = IMM_W'(bundle_q.imm);
   assign alu_op         = bundle_q.alu;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage; expected bundles are queued at issue
// and a monitor pops and compares them whenever execute accepts an output.
module tb_decode_stage;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [8:0] in_instr;
   logic [9:0] in_pc;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out_pc;
   logic [1:0] R1, R2, W;
   logic       write_en, mem_write, mem_read, use_alu_bypass, alu_src;
   logic [7:0] imm;
   logic [4:0] alu_op;
   logic [33:0] got;
   logic [33:0] exp_q[$];
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .R1(R1), .R2(R2), .W(W),
      .write_en(write_en), .mem_write(mem_write), .mem_read(mem_read),
      .use_alu_bypass(use_alu_bypass), .alu_src(alu_src), .imm(imm), .alu_op(alu_op)
   );

   assign got = {out_pc, R1, R2, W, write_en, mem_write, mem_read, use_alu_bypass, alu_src, imm, alu_op};

   // fl = {write_en, mem_write, mem_read, use_alu_bypass, alu_src}
   function automatic logic [33:0] e(input logic [9:0] pc, input logic [1:0] r1, input logic [1:0] r2,
                                     input logic [1:0] w, input logic [4:0] fl, input logic [7:0] im,
                                     input logic [4:0] alu);
      return {pc, r1, r2, w, fl, im, alu};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (n) step();
   endtask

   task automatic issue(input logic [8:0] ins, input logic [9:0] pc, input logic [33:0] ex,
                        input bit push, input int waits, input int ov, input string nm);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      check({nm, "_waits"}, 64'(n), 64'(waits));
      if (ov >= 0) check({nm, "_valid"}, 64'(out_valid), 64'(ov));
      if (in_ready && push) exp_q.push_back(ex);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   initial begin
      logic [33:0] ex;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_unexpected: got 0x%0h expected no output", got);
            end else begin
               ex = exp_q.pop_front();
               check("sb_bundle", 64'(got), 64'(ex));
            end
         end
      end
   end

   int codes[12] = '{4, 5, 6, 7, 8, 10, 11, 15, 12, 13, 14, 9};
   int alus[12]  = '{13, 14, 15, 16, 17, 18, 19, 20, 4, 5, 6, 19};
   bit wes[12]   = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
      #2;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_bundle", 64'(got), 64'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'(1));
      step();

      // decode table, streamed back to back
      issue(9'h0B4, 10'h010, e(10'h010, 0, 0, 3, 5'b10011, 4, 7), 1, 0, -1, "mov");
      issue(9'h0F8, 10'h011, e(10'h011, 3, 0, 3, 5'b10011, 8, 10), 1, 0, 1, "shl_neg8");
      issue(9'h0E3, 10'h012, e(10'h012, 2, 0, 2, 5'b10011, 3, 11), 1, 0, 1, "shr3");
      issue(9'h0DD, 10'h013, e(10'h013, 1, 0, 1, 5'b10011, 3, 10), 1, 0, 1, "shl_neg3");
      issue(9'h039, 10'h014, e(10'h014, 2, 3, 0, 5'b01001, 1, 0), 1, 0, 1, "str");
      issue(9'h100, 10'h015, e(10'h015, 0, 0, 0, 5'b10010, 0, 0), 1, 0, 1, "add");
      issue(9'h11C, 10'h016, e(10'h016, 3, 0, 3, 5'b10010, 0, 1), 1, 0, 1, "sub");
      issue(9'h125, 10'h017, e(10'h017, 1, 1, 1, 5'b10010, 0, 3), 1, 0, 1, "copy");
      issue(9'h136, 10'h018, e(10'h018, 1, 2, 2, 5'b10010, 0, 2), 1, 0, 1, "abs");
      issue(9'h14B, 10'h019, e(10'h019, 2, 3, 0, 5'b00010, 0, 12), 1, 0, 1, "cmp");
      issue(9'h188, 10'h01A, e(10'h01A, 2, 0, 0, 5'b10010, 0, 9), 1, 0, 1, "xor");
      issue(9'h1C5, 10'h01B, e(10'h01B, 1, 1, 0, 5'b10010, 0, 8), 1, 0, 1, "and");
      drain(3);

      // jump sweep
      for (int i = 0; i < 12; i++)
         issue({3'b101, 4'(codes[i]), 2'b01}, 10'(10'h200 + i),
               e(10'(10'h200 + i), 0, 1, 1, {wes[i], 4'b0010}, 0, 5'(alus[i])), 1, 0, -1, "jmp");
      drain(3);

      // backpressure: outputs hold, next instruction neither lost nor duplicated
      issue(9'h0B4, 10'h040, e(10'h040, 0, 0, 3, 5'b10011, 4, 7), 1, 0, -1, "hold_mov");
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 9'h039;
      in_pc     = 10'h041;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_in_ready", 64'(in_ready), 64'(0));
         check("hold_bundle", 64'(got), 64'(e(10'h040, 0, 0, 3, 5'b10011, 4, 7)));
         step();
      end
      out_ready = 1'b1;
      issue(9'h039, 10'h041, e(10'h041, 2, 3, 0, 5'b01001, 1, 0), 1, 0, 1, "hold_str");
      drain(3);

      // load-use: back-to-back non-dependent passes, following dependent gets a bubble
      issue(9'h060, 10'h100, e(10'h100, 0, 0, 2, 5'b10101, 0, 0), 1, 0, -1, "ldr_a");
      issue(9'h1C5, 10'h101, e(10'h101, 1, 1, 0, 5'b10010, 0, 8), 1, 0, 1, "and_next");
      issue(9'h188, 10'h102, e(10'h102, 2, 0, 0, 5'b10010, 0, 9), 1, 1, 0, "xor_dep");
      drain(3);
      issue(9'h060, 10'h110, e(10'h110, 0, 0, 2, 5'b10101, 0, 0), 1, 0, -1, "ldr_b");
      step();
      issue(9'h1C5, 10'h111, e(10'h111, 1, 1, 0, 5'b10010, 0, 8), 1, 0, 0, "and_nodep_hz");
      drain(3);
      issue(9'h060, 10'h118, e(10'h118, 0, 0, 2, 5'b10101, 0, 0), 1, 0, -1, "ldr_c");
      step();
      issue(9'h020, 10'h119, e(10'h119, 0, 2, 0, 5'b01001, 0, 0), 1, 1, 0, "str_dep_r2");
      drain(3);

      // flush while a bundle is held and the hazard counter is live
      issue(9'h060, 10'h120, e(10'h120, 0, 0, 2, 5'b10101, 0, 0), 1, 0, -1, "ldr_f");
      issue(9'h1C5, 10'h121, '0, 0, 0, 1, "and_killed");
      flush = 1'b1; in_valid = 1'b1; in_instr = 9'h0B4; in_pc = 10'h122;
      @(negedge clk);
      check("flush_in_ready", 64'(in_ready), 64'(0));
      check("flush_pre_valid", 64'(out_valid), 64'(1));
      step();
      flush = 1'b0; in_valid = 1'b0;
      issue(9'h188, 10'h123, e(10'h123, 2, 0, 0, 5'b10010, 0, 9), 1, 0, 0, "xor_post_flush");
      drain(3);

      // asynchronous reset mid-operation drops the held bundle and the hazard
      issue(9'h060, 10'h130, e(10'h130, 0, 0, 2, 5'b10101, 0, 0), 1, 0, -1, "ldr_r");
      issue(9'h1C5, 10'h131, '0, 0, 0, 1, "and_dropped");
      out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("midrst_valid", 64'(out_valid), 64'(0));
      check("midrst_bundle", 64'(got), 64'(0));
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      issue(9'h188, 10'h132, e(10'h132, 2, 0, 0, 5'b10010, 0, 9), 1, 0, 0, "xor_post_reset");
      drain(4);

      check("sb_drain", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
